// File: rtl/fetch_unit.sv
// MIPS instruction-fetch stage: owns the PC, computes redirect targets from ID-stage requests,
// and registers the fetched word into the IF/ID pipeline register.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0040_0000,
  parameter bit          DELAY_SLOT = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] pc_out,
  input  logic [31:0] instr_in,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [15:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jump_reg,
  input  logic [31:0] reg_target,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic [31:0] fetch_count
);

  logic [31:0] r_pc;
  logic [31:0] r_if_id_instr;
  logic [31:0] r_if_id_pc_plus4;
  logic        r_if_id_valid;
  logic [31:0] r_fetch_count;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_branch_tgt;
  logic [31:0] w_jump_tgt;
  logic [31:0] w_jr_tgt;
  logic [31:0] w_next_pc;
  logic        w_redirect;
  logic        w_squash;
  logic        w_advance;

  // Targets are relative to the instruction sitting in ID, not the one being fetched.
  assign w_pc_plus4   = r_pc + 32'd4;
  assign w_branch_tgt = r_if_id_pc_plus4 + {{14{branch_offset[15]}}, branch_offset, 2'b00};
  assign w_jump_tgt   = {r_if_id_pc_plus4[31:28], jump_index, 2'b00};
  assign w_jr_tgt     = {reg_target[31:2], 2'b00};

  always_comb begin
    w_next_pc = w_pc_plus4;
    if (jump_reg) begin
      w_next_pc = w_jr_tgt;
    end else if (jump) begin
      w_next_pc = w_jump_tgt;
    end else if (branch_taken) begin
      w_next_pc = w_branch_tgt;
    end
  end

  assign w_redirect = jump_reg | jump | branch_taken;
  assign w_squash   = !DELAY_SLOT && !stall && w_redirect;
  assign w_advance  = !stall && !flush && !w_squash;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc             <= RESET_PC;
      r_if_id_instr    <= 32'h0;
      r_if_id_pc_plus4 <= 32'h0;
      r_if_id_valid    <= 1'b0;
      r_fetch_count    <= 32'h0;
    end else begin
      if (!stall) begin
        r_pc             <= w_next_pc;
        r_if_id_pc_plus4 <= w_pc_plus4;
      end
      // Flush overrides stall for IF/ID; a squashed delay slot becomes a NOP bubble.
      if (flush || w_squash) begin
        r_if_id_instr <= 32'h0;
        r_if_id_valid <= 1'b0;
      end else if (!stall) begin
        r_if_id_instr <= instr_in;
        r_if_id_valid <= 1'b1;
      end
      if (w_advance) begin
        r_fetch_count <= r_fetch_count + 32'd1;
      end
    end
  end

  assign pc_out         = r_pc;
  assign if_id_instr    = r_if_id_instr;
  assign if_id_pc_plus4 = r_if_id_pc_plus4;
  assign if_id_valid    = r_if_id_valid;
  assign fetch_count    = r_fetch_count;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the MIPS pipeline.
- Owns the program counter and drives `pc_out` straight into InstMemory's `address` input. Samples the combinational `data_out` in the same cycle and registers it into the IF/ID pipeline register.
- Computes branch/jump/jump-register next-PC from redirect requests raised by the ID stage, handles stall and flush, and keeps a fetch counter for performance debug.

Parameters:
- RESET_PC, 32'h00400000, PC value loaded on reset (MIPS text base; InstMemory maps it to word 0).
- DELAY_SLOT, 1, 1 = the instruction fetched during a redirect cycle is kept (architectural delay slot); 0 = it is squashed.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- pc_out  output  32  current PC, to InstMemory address.
- instr_in  input  32  instruction word from InstMemory data_out.
- stall  input  1  hazard unit hold: freeze PC and IF/ID.
- flush  input  1  invalidate IF/ID contents.
- branch_taken  input  1  ID stage: conditional branch resolved taken.
- branch_offset  input  16  branch immediate (word offset, signed).
- jump  input  1  ID stage: J/JAL.
- jump_index  input  26  J-type target field.
- jump_reg  input  1  ID stage: JR/JALR.
- reg_target  input  32  register value for JR/JALR.
- if_id_instr  output  32  registered instruction.
- if_id_pc_plus4  output  32  registered PC+4 of that instruction.
- if_id_valid  output  1  IF/ID holds a live instruction.
- fetch_count  output  32  count of instructions accepted into IF/ID.

Behaviour:
- Reset (rst_n low, asynchronous):
  - pc = RESET_PC.
  - if_id_instr = 32'h0 (NOP); if_id_pc_plus4 = 0; if_id_valid = 0; fetch_count = 0.
  - The first rising edge after release fetches RESET_PC.
- Timing: pc_out is the PC register output, with no combinational path from any input to pc_out. The fetch of the word at pc_out is visible on if_id_instr one cycle later.
- Arithmetic (all 32-bit, modulo 2^32; PC+4 from 0xFFFFFFFC wraps to 0):
  - pc_plus4 = pc + 4.
  - Branch and jump targets use if_id_pc_plus4, i.e. the PC+4 of the instruction in ID.
  - branch target = if_id_pc_plus4 + (sign_extend(branch_offset) << 2).
  - jump target = {if_id_pc_plus4[31:28], jump_index, 2'b00}.
  - jr target = {reg_target[31:2], 2'b00`; low two bits are forced to 0, with no trap.
- Next-PC priority: jump_reg > jump > branch_taken > pc_plus4.
- Update rules, per rising edge:
  - stall=1:
    - PC holds, fetch_count holds, and redirect inputs are ignored. The ID stage keeps redirects asserted until stall drops.
    - IF/ID holds unless flush=1.
  - stall=0:
    - pc <= next_pc.
    - if_id_instr <= instr_in; if_id_pc_plus4 <= pc_plus4; if_id_valid <= 1.
    - fetch_count <= fetch_count + 1, wrapping.
  - Redirect with DELAY_SLOT=0 (stall=0, any redirect asserted): if_id_valid <= 0, if_id_instr <= 0, and fetch_count does not increment.
  - Redirect with DELAY_SLOT=1: the delay-slot instruction loads normally.
  - flush=1: if_id_valid <= 0 and if_id_instr <= 0 regardless of stall. PC still follows the stall/redirect rules, and fetch_count does not increment that cycle.
- Simultaneous events:
  - Multiple redirects in one cycle: the priority above applies and the lower-priority ones are dropped.
  - flush + stall: flush wins for IF/ID, stall wins for PC.
  - flush + redirect (stall=0): PC takes the redirect target, IF/ID is flushed.
- Reset asserted mid-operation immediately returns every output to its reset value. No in-flight state survives.
- Programs must stay within InstMemory's MEM_SIZE words, because InstMemory returns X beyond that range. fetch_unit passes instr_in through without inspection.

Test Plan:
- Reset/sequential: hold rst_n low 3 cycles, release; memory words 0..3 = 0x11111111..0x44444444 -> pc_out 0x00400000, 0x00400004, ...; if_id_instr 0x11111111 with if_id_pc_plus4 0x00400004 one cycle later; fetch_count = 4 after 4 cycles.
- Branch: if_id_pc_plus4 = 0x00400008, branch_taken=1, branch_offset=16'hFFFE -> next pc_out = 0x00400000. With DELAY_SLOT=0, if_id_valid = 0 the following cycle.
- Jump priority: jump=1, jump_index=26'h0100010, branch_taken=1 simultaneously -> pc_out = 0x00400040. Add jump_reg=1 with reg_target=0x00400103 -> pc_out = 0x00400100 instead.
- Stall/flush: stall=1 for 3 cycles -> pc_out, if_id_* and fetch_count frozen. stall=1 with flush=1 -> if_id_valid = 0, if_id_instr = 0, pc_out unchanged.
- Wrap and reset mid-run: force pc to 0xFFFFFFFC via jr (reg_target=0xFFFFFFFC) -> next pc_out = 0x00000000. Assert rst_n low mid-cycle -> pc_out = 0x00400000 and if_id_valid = 0 immediately, without waiting for a clock edge.
